// File: rtl/rt_pkg.sv
// rt_pkg: shared types and constants for the scene loader front end.
// Default build: 27-word scene, 32-bit AXIS data.
package rt_pkg;
  localparam int SCENE_WORDS = 27;
  localparam int AXIS_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    ARMED,
    BUSY
  } loader_state_t;

  typedef logic [$clog2(SCENE_WORDS+1)-1:0] scene_idx_t;
endpackage

// File: rtl/scene_loader.sv
// scene_loader: AXIS slave that frames, stages and commits a scene bank.
// SCENE_LOADER_CKSUM_EN adds a trailing mod-2^32 checksum beat.
module scene_loader
  import rt_pkg::*;
#(
  parameter int DATA_W        = AXIS_DATA_W,
  parameter int PAYLOAD_WORDS = SCENE_WORDS
) (
  input  logic                            aclk,
  input  logic                            resetn,
  output logic                            s_axis_tready,
  input  logic [DATA_W-1:0]               s_axis_tdata,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tvalid,
  output logic [PAYLOAD_WORDS*DATA_W-1:0] scene_o,
  output logic                            start_o,
  input  logic                            render_done_i,
  output logic                            busy_o,
`ifdef SCENE_LOADER_CKSUM_EN
  output logic                            err_cksum_o,
`endif
  output logic                            err_short_o,
  output logic                            err_long_o
);
  localparam int CW = $clog2(PAYLOAD_WORDS+1);
`ifdef SCENE_LOADER_CKSUM_EN
  localparam int FRAME_LEN = PAYLOAD_WORDS + 1;
`else
  localparam int FRAME_LEN = PAYLOAD_WORDS;
`endif
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  typedef logic [PAYLOAD_WORDS-1:0][DATA_W-1:0] bank_t;

  loader_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  bank_t stage_q, stage_d;
  bank_t scene_q, scene_d;
  logic rdy_q;
  logic err_short_q, err_short_d;
  logic err_long_q, err_long_d;
  logic beat, store, sum_ok;

`ifdef SCENE_LOADER_CKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
  logic err_cksum_q, err_cksum_d;
  // the checksum beat sits past the bank and is only compared
  assign store       = cnt_q < CW'(PAYLOAD_WORDS);
  assign sum_ok      = sum_q == s_axis_tdata;
  assign err_cksum_o = err_cksum_q;
`else
  assign store  = 1'b1;
  assign sum_ok = 1'b1;
`endif

  assign beat        = s_axis_tvalid && s_axis_tready;
  assign scene_o     = scene_q;
  assign err_short_o = err_short_q;
  assign err_long_o  = err_long_q;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stage_q     <= '0;
      scene_q     <= '0;
      rdy_q       <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
`ifdef SCENE_LOADER_CKSUM_EN
      sum_q       <= '0;
      err_cksum_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stage_q     <= stage_d;
      scene_q     <= scene_d;
      rdy_q       <= 1'b1;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
`ifdef SCENE_LOADER_CKSUM_EN
      sum_q       <= sum_d;
      err_cksum_q <= err_cksum_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stage_d     = stage_q;
    scene_d     = scene_q;
    err_short_d = err_short_q;
    err_long_d  = err_long_q;
`ifdef SCENE_LOADER_CKSUM_EN
    sum_d       = sum_q;
    err_cksum_d = err_cksum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          if (store) begin
            stage_d[cnt_q] = s_axis_tdata;
`ifdef SCENE_LOADER_CKSUM_EN
            sum_d = sum_q + s_axis_tdata;
`endif
          end
          if (s_axis_tlast) begin
            cnt_d = '0;
`ifdef SCENE_LOADER_CKSUM_EN
            sum_d = '0;
`endif
            if (cnt_q != LAST_IDX) begin
              err_short_d = 1'b1;
            end else if (!sum_ok) begin
`ifdef SCENE_LOADER_CKSUM_EN
              err_cksum_d = 1'b1;
`endif
            end else begin
              scene_d = stage_d;
              state_d = ARMED;
            end
          end else if (cnt_q == LAST_IDX) begin
            err_long_d = 1'b1;
            state_d    = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (beat && s_axis_tlast) begin
          cnt_d   = '0;
          state_d = IDLE;
`ifdef SCENE_LOADER_CKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      ARMED: state_d = BUSY;
      BUSY: begin
        if (render_done_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b0;
    start_o       = 1'b0;
    busy_o        = 1'b0;
    unique case (state_q)
      IDLE, DRAIN: s_axis_tready = rdy_q;
      ARMED: begin
        start_o = 1'b1;
        busy_o  = 1'b1;
      end
      BUSY: busy_o = 1'b1;
      default: ;
    endcase
  end
endmodule
